// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants and state encodings for the SS.cc stopwatch.
// Digit widths and limits keep every digit in legal BCD range.
package stopwatch_pkg;

  localparam int DIGIT_W      = 4;
  localparam int CS_MAX       = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  typedef enum logic {
    LAP_LIVE   = 1'b0,
    LAP_FROZEN = 1'b1
  } lap_state_e;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control pulses in, packed BCD display value and status out.
// The controller uses master; the stopwatch uses slave.
interface bcd_stopwatch_if;
  import stopwatch_pkg::*;

  logic                   i_start_stop;
  logic                   i_clear;
  logic                   i_lap;
  logic [4*DIGIT_W-1:0]   o_bcd;
  logic                   o_running;
  logic                   o_wrap;

  modport master (
    output i_start_stop, i_clear, i_lap,
    input  o_bcd, o_running, o_wrap
  );

  modport slave (
    input  i_start_stop, i_clear, i_lap,
    output o_bcd, o_running, o_wrap
  );

endinterface

// File: rtl/bcd_stopwatch_digit.sv
// One BCD digit counting 0..MAX; clr beats inc, carry flags the MAX->0 step.
// q updates on the edge after inc; carry is combinational from inc.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] q_q, q_d;

  assign carry = inc && (q_q == MAX_V);
  assign q     = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == MAX_V) ? '0 : q_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// SS.cc stopwatch producing packed BCD for hex_display; o_bcd lags a tick by one cycle.
// No backpressure; optional lap freeze under STOPWATCH_LAP_EN.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int DIV_W    = 20
) (
  input  logic            clk,
  input  logic            rst,
  bcd_stopwatch_if.slave  sw
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  run_state_e           run_q, run_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 wrap_q, wrap_d;
  logic                 tick;
  logic [3:0]           carry;
  logic [DIGIT_W-1:0]   cs_ones, cs_tens, sec_ones, sec_tens;
  logic [4*DIGIT_W-1:0] live_bcd;

  assign tick     = (run_q == ST_RUNNING) && (div_q == DIV_LAST);
  assign live_bcd = {sec_tens, sec_ones, cs_tens, cs_ones};

  always_comb begin
    run_d  = run_q;
    div_d  = div_q;
    wrap_d = 1'b0;
    if (sw.i_start_stop) begin
      run_d = (run_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
    // A clear swallows a coincident tick, including its wrap.
    if (sw.i_clear) begin
      div_d = '0;
    end else if (tick) begin
      div_d  = '0;
      wrap_d = carry[3];
    end else if (run_q == ST_RUNNING) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= ST_STOPPED;
      div_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      div_q  <= div_d;
      wrap_q <= wrap_d;
    end
  end

  bcd_digit #(.MAX(CS_MAX)) u_cs_ones (
    .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(tick),
    .q(cs_ones), .carry(carry[0])
  );
  bcd_digit #(.MAX(CS_MAX)) u_cs_tens (
    .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(carry[0]),
    .q(cs_tens), .carry(carry[1])
  );
  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(carry[1]),
    .q(sec_ones), .carry(carry[2])
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(sw.i_clear), .inc(carry[2]),
    .q(sec_tens), .carry(carry[3])
  );

  assign sw.o_running = (run_q == ST_RUNNING);
  assign sw.o_wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
  lap_state_e           lap_state_q, lap_state_d;
  logic [4*DIGIT_W-1:0] lap_q, lap_d;

  always_comb begin
    lap_state_d = lap_state_q;
    lap_d       = lap_q;
    if (sw.i_clear) begin
      lap_state_d = LAP_LIVE;
      lap_d       = '0;
    end else if (sw.i_lap) begin
      if (lap_state_q == LAP_LIVE) begin
        lap_state_d = LAP_FROZEN;
        lap_d       = live_bcd;
      end else begin
        lap_state_d = LAP_LIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_state_q <= LAP_LIVE;
      lap_q       <= '0;
    end else begin
      lap_state_q <= lap_state_d;
      lap_q       <= lap_d;
    end
  end

  assign sw.o_bcd = (lap_state_q == LAP_FROZEN) ? lap_q : live_bcd;
`else
  logic unused_lap;
  assign unused_lap = sw.i_lap;
  assign sw.o_bcd   = live_bcd;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Stopwatch bench: directed phases then random pulses, checked every cycle
// against a centisecond-count reference model.
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 4;

  logic clk;
  logic rst;

  bcd_stopwatch_if sw_if ();

  bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int n_wrap_seen;

  // Reference model: elapsed centiseconds, run flag, cycles into current tick.
  int m_cs;
  bit m_run;
  int m_pre;
  bit m_wrap;
  bit m_frozen;
  int m_lap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic m_edge(input bit ss, input bit cl, input bit lp, input bit r);
    bit tick;
    int old_cs;
    if (r) begin
      m_cs = 0; m_run = 0; m_pre = 0; m_wrap = 0; m_frozen = 0; m_lap = 0;
    end else begin
      tick   = m_run && (m_pre == TICK_DIV - 1);
      old_cs = m_cs;
      m_wrap = 0;
      if (cl) begin
        m_cs = 0; m_pre = 0;
      end else if (tick) begin
        m_wrap = (m_cs == 5999);
        m_cs   = (m_cs + 1) % 6000;
        m_pre  = 0;
      end else if (m_run) begin
        m_pre++;
      end
      if (ss) m_run = !m_run;
`ifdef STOPWATCH_LAP_EN
      if (cl) begin
        m_frozen = 0; m_lap = 0;
      end else if (lp) begin
        if (!m_frozen) begin
          m_lap = old_cs; m_frozen = 1;
        end else begin
          m_frozen = 0;
        end
      end
`endif
    end
  endtask

  task automatic cyc(input bit ss, input bit cl, input bit lp, input bit r);
    sw_if.i_start_stop = ss;
    sw_if.i_clear      = cl;
    sw_if.i_lap        = lp;
    rst                = r;
    @(posedge clk);
    m_edge(ss, cl, lp, r);
    #1;
    chk("bcd", 32'(sw_if.o_bcd), 32'(to_bcd(m_frozen ? m_lap : m_cs)));
    chk("running", 32'(sw_if.o_running), 32'(m_run));
    chk("wrap", 32'(sw_if.o_wrap), 32'(m_wrap));
    if (sw_if.o_wrap === 1'b1) n_wrap_seen++;
    sw_if.i_start_stop = 1'b0;
    sw_if.i_clear      = 1'b0;
    sw_if.i_lap        = 1'b0;
    rst                = 1'b0;
  endtask

  // Idle-step until the model reaches the target (-1 = don't care), bounded.
  task automatic run_until(input int t_cs, input int t_pre, input int limit, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      if ((t_cs < 0 || m_cs == t_cs) && (t_pre < 0 || m_pre == t_pre)) ok = 1;
      else cyc(0, 0, 0, 0);
    end
    chk({tag, "_reached"}, 32'(ok), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_wrap_seen = 0;
    sw_if.i_start_stop = 1'b0;
    sw_if.i_clear      = 1'b0;
    sw_if.i_lap        = 1'b0;
    rst                = 1'b1;

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_bcd", 32'(sw_if.o_bcd), 32'h0000);
    chk("rst_running", 32'(sw_if.o_running), 32'd0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("idle_bcd", 32'(sw_if.o_bcd), 32'h0000);
    chk("idle_wraps", 32'(n_wrap_seen), 32'd0);

    cyc(1, 0, 0, 0);
    chk("start_running", 32'(sw_if.o_running), 32'd1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0);
    chk("ten_ticks", 32'(sw_if.o_bcd), 32'h0010);

    run_until(5999, -1, 30000, "pre_wrap");
    run_until(0, -1, 10, "post_wrap");
    chk("wrap_count", 32'(n_wrap_seen), 32'd1);
    chk("wrap_still_running", 32'(sw_if.o_running), 32'd1);

    run_until(-1, 2, 10, "pre_two");
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    run_until(5, TICK_DIV - 1, 100, "clr_tick_pos");
    cyc(0, 1, 0, 0);
    chk("clr_tick_bcd", 32'(sw_if.o_bcd), 32'h0000);
    chk("clr_tick_run", 32'(sw_if.o_running), 32'd1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("clr_ss_bcd", 32'(sw_if.o_bcd), 32'h0000);
    chk("clr_ss_run", 32'(sw_if.o_running), 32'd0);

    cyc(1, 0, 0, 0);
    run_until(12, -1, 200, "lap_pos");
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
`ifdef STOPWATCH_LAP_EN
    chk("lap_hold", 32'(sw_if.o_bcd), 32'h0012);
`else
    chk("lap_ignored", 32'(sw_if.o_bcd), 32'(to_bcd(m_cs)));
`endif
    cyc(0, 0, 1, 0);
    chk("lap_release", 32'(sw_if.o_bcd), 32'(to_bcd(m_cs)));

    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 16) == 0, ($urandom % 64) == 0,
          ($urandom % 16) == 0, ($urandom % 512) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
